// File: rtl/k_and_s_pkg.sv
// rtl/k_and_s_pkg.sv - shared K&S CPU types: decoded instructions, controller states, ALU codes
package k_and_s_pkg;

    typedef enum logic [3:0] {
        I_NOP,
        I_LOAD,
        I_STORE,
        I_MOVE,
        I_ADD,
        I_SUB,
        I_AND,
        I_OR,
        I_BRANCH,
        I_BZERO,
        I_BNZERO,
        I_BNEG,
        I_BNNEG,
        I_BOV,
        I_BNOV,
        I_HALT
    } decoded_instruction_type;

    typedef enum logic [1:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALT
    } ctrl_state_t;

    localparam logic [1:0] ALU_OR  = 2'b00;
    localparam logic [1:0] ALU_ADD = 2'b01;
    localparam logic [1:0] ALU_SUB = 2'b10;
    localparam logic [1:0] ALU_AND = 2'b11;

endpackage

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle FETCH/DECODE/EXEC sequencer driving data_path and RAM strobes
module control_unit
    import k_and_s_pkg::*;
#(
    parameter int MEM_WAIT = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  decoded_instruction_type decoded_instruction,
    input  logic                    zero_op,
    input  logic                    neg_op,
    input  logic                    unsigned_overflow,
    input  logic                    signed_overflow,
    output logic                    branch,
    output logic                    pc_enable,
    output logic                    ir_enable,
    output logic                    addr_sel,
    output logic                    c_sel,
    output logic [1:0]              operation,
    output logic                    write_reg_enable,
    output logic                    flags_reg_enable,
    output logic                    ram_write_enable,
    output logic                    halt
);

    localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

    ctrl_state_t state;
    ctrl_state_t state_next;
    logic [2:0]  wait_cnt;
    logic        mem_done;

    // No instruction consults the unsigned-overflow flag; kept on the port for data_path symmetry.
    logic unused_flags;
    assign unused_flags = unsigned_overflow;

    // Conditional-branch evaluation; non-branch codes are never taken.
    function automatic logic branch_taken(input decoded_instruction_type instr,
                                          input logic z, input logic n, input logic v);
        case (instr)
            I_BRANCH: branch_taken = 1'b1;
            I_BZERO:  branch_taken = z;
            I_BNZERO: branch_taken = !z;
            I_BNEG:   branch_taken = n;
            I_BNNEG:  branch_taken = !n;
            I_BOV:    branch_taken = v;
            I_BNOV:   branch_taken = !v;
            default:  branch_taken = 1'b0;
        endcase
    endfunction

    assign mem_done = (wait_cnt == WAIT_LAST);

    // State register and memory wait counter; counter restarts on every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_FETCH;
            wait_cnt <= 3'd0;
        end else begin
            state <= state_next;
            if (state_next != state)
                wait_cnt <= 3'd0;
            else if (wait_cnt < WAIT_LAST)
                wait_cnt <= wait_cnt + 3'd1;
        end
    end

    // Next-state and output decode of the current state and instruction.
    always_comb begin
        state_next       = state;
        branch           = 1'b0;
        pc_enable        = 1'b0;
        ir_enable        = 1'b0;
        addr_sel         = 1'b1;
        c_sel            = 1'b1;
        operation        = ALU_OR;
        write_reg_enable = 1'b0;
        flags_reg_enable = 1'b0;
        ram_write_enable = 1'b0;
        halt             = 1'b0;
        case (state)
            S_FETCH: begin
                if (mem_done) begin
                    ir_enable  = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                pc_enable  = 1'b1;
                state_next = (decoded_instruction == I_HALT) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                state_next = S_FETCH;
                case (decoded_instruction)
                    I_LOAD: begin
                        addr_sel = 1'b0;
                        c_sel    = 1'b0;
                        if (mem_done)
                            write_reg_enable = 1'b1;
                        else
                            state_next = S_EXEC;
                    end
                    I_STORE: begin
                        addr_sel = 1'b0;
                        if (mem_done)
                            ram_write_enable = 1'b1;
                        else
                            state_next = S_EXEC;
                    end
                    I_ADD, I_SUB, I_AND, I_OR: begin
                        case (decoded_instruction)
                            I_ADD:   operation = ALU_ADD;
                            I_SUB:   operation = ALU_SUB;
                            I_AND:   operation = ALU_AND;
                            default: operation = ALU_OR;
                        endcase
                        write_reg_enable = 1'b1;
                        flags_reg_enable = 1'b1;
                    end
                    I_MOVE: begin
                        write_reg_enable = 1'b1;
                    end
                    I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV: begin
                        if (branch_taken(decoded_instruction, zero_op, neg_op, signed_overflow)) begin
                            pc_enable = 1'b1;
                            branch    = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            S_HALT: begin
                halt = 1'b1;
            end
            default: state_next = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed self-checking bench for control_unit (MEM_WAIT 0 and 2)
module tb_control_unit;
    import k_and_s_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    decoded_instruction_type instr = I_NOP;
    logic zero_op = 1'b0, neg_op = 1'b0, uov = 1'b0, sov = 1'b0;

    logic a_br, a_pc, a_ir, a_addr, a_csel, a_wre, a_fre, a_rwe, a_halt;
    logic [1:0] a_op;
    logic b_br, b_pc, b_ir, b_addr, b_csel, b_wre, b_fre, b_rwe, b_halt;
    logic [1:0] b_op;

    int n_checks = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    control_unit #(.MEM_WAIT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .decoded_instruction(instr),
        .zero_op(zero_op), .neg_op(neg_op), .unsigned_overflow(uov), .signed_overflow(sov),
        .branch(a_br), .pc_enable(a_pc), .ir_enable(a_ir), .addr_sel(a_addr), .c_sel(a_csel),
        .operation(a_op), .write_reg_enable(a_wre), .flags_reg_enable(a_fre),
        .ram_write_enable(a_rwe), .halt(a_halt)
    );

    control_unit #(.MEM_WAIT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .decoded_instruction(instr),
        .zero_op(zero_op), .neg_op(neg_op), .unsigned_overflow(uov), .signed_overflow(sov),
        .branch(b_br), .pc_enable(b_pc), .ir_enable(b_ir), .addr_sel(b_addr), .c_sel(b_csel),
        .operation(b_op), .write_reg_enable(b_wre), .flags_reg_enable(b_fre),
        .ram_write_enable(b_rwe), .halt(b_halt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Reset both instances; returns at a falling edge with both in the first FETCH cycle.
    task automatic do_reset(input decoded_instruction_type ins);
        instr = ins;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Run one branch-type instruction on dut0 and check the EXEC cycle.
    task automatic run_branch(input decoded_instruction_type ins, input int fsel,
                              input logic v, input logic taken);
        zero_op = !v; neg_op = !v; sov = !v; uov = !v;
        case (fsel)
            0: zero_op = v;
            1: neg_op  = v;
            default: sov = v;
        endcase
        do_reset(ins);
        step();
        check($sformatf("%s dec pc", ins.name()), a_pc, 1);
        check($sformatf("%s dec br", ins.name()), a_br, 0);
        step();
        check($sformatf("%s v=%0b pc", ins.name(), v), a_pc, taken);
        check($sformatf("%s v=%0b br", ins.name(), v), a_br, taken);
        check($sformatf("%s v=%0b fre", ins.name(), v), a_fre, 0);
        check($sformatf("%s v=%0b wre", ins.name(), v), a_wre, 0);
    endtask

    initial begin
        // Reset values while rst_n held low
        step();
        check("rst ir0", a_ir, 1);
        check("rst ir2", b_ir, 0);
        check("rst addr", a_addr, 1);
        check("rst strobes", {a_pc, a_br, a_wre, a_fre, a_rwe, a_halt}, 0);

        // ADD stream, MEM_WAIT=0
        do_reset(I_ADD);
        check("add fetch ir", a_ir, 1);
        step();
        check("add dec pc", a_pc, 1);
        check("add dec br", a_br, 0);
        check("add dec ir", a_ir, 0);
        step();
        check("add op", a_op, 2'b01);
        check("add csel", a_csel, 1);
        check("add wre", a_wre, 1);
        check("add fre", a_fre, 1);
        check("add pc", a_pc, 0);
        step();
        check("add next ir", a_ir, 1);
        check("add next wre", a_wre, 0);

        // SUB and AND operation codes
        do_reset(I_SUB);
        step(); step();
        check("sub op", a_op, 2'b10);
        do_reset(I_AND);
        step(); step();
        check("and op", a_op, 2'b11);
        do_reset(I_OR);
        step(); step();
        check("or op", a_op, 2'b00);
        check("or fre", a_fre, 1);

        // Async reset in the middle of ADD's EXEC cycle
        do_reset(I_ADD);
        step(); step();
        check("mid wre before", a_wre, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid wre", a_wre, 0);
        check("mid fre", a_fre, 0);
        check("mid state", dut0.state, S_FETCH);
        check("mid ir", a_ir, 1);
        check("mid addr", a_addr, 1);

        // STORE with MEM_WAIT=2
        do_reset(I_STORE);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("st fetch%0d ir", i), b_ir, (i == 2) ? 1 : 0);
            check($sformatf("st fetch%0d addr", i), b_addr, 1);
            step();
        end
        check("st dec pc", b_pc, 1);
        step();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("st exec%0d addr", i), b_addr, 0);
            check($sformatf("st exec%0d rwe", i), b_rwe, (i == 2) ? 1 : 0);
            check($sformatf("st exec%0d wre", i), b_wre, 0);
            step();
        end
        check("st after addr", b_addr, 1);
        check("st after rwe", b_rwe, 0);
        check("st after ir", b_ir, 0);

        // LOAD with MEM_WAIT=2
        do_reset(I_LOAD);
        step(); step(); step();
        step();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("ld exec%0d addr", i), b_addr, 0);
            check($sformatf("ld exec%0d csel", i), b_csel, 0);
            check($sformatf("ld exec%0d wre", i), b_wre, (i == 2) ? 1 : 0);
            check($sformatf("ld exec%0d rwe", i), b_rwe, 0);
            step();
        end
        check("ld after wre", b_wre, 0);

        // LOAD/STORE with MEM_WAIT=0 complete in one EXEC cycle
        do_reset(I_STORE);
        step(); step();
        check("st0 rwe", a_rwe, 1);
        check("st0 addr", a_addr, 0);
        step();
        check("st0 next ir", a_ir, 1);

        // Branch matrix
        run_branch(I_BZERO,  0, 1'b1, 1'b1);
        run_branch(I_BZERO,  0, 1'b0, 1'b0);
        run_branch(I_BNZERO, 0, 1'b0, 1'b1);
        run_branch(I_BNZERO, 0, 1'b1, 1'b0);
        run_branch(I_BNEG,   1, 1'b1, 1'b1);
        run_branch(I_BNEG,   1, 1'b0, 1'b0);
        run_branch(I_BNNEG,  1, 1'b0, 1'b1);
        run_branch(I_BNNEG,  1, 1'b1, 1'b0);
        run_branch(I_BOV,    2, 1'b1, 1'b1);
        run_branch(I_BOV,    2, 1'b0, 1'b0);
        run_branch(I_BNOV,   2, 1'b0, 1'b1);
        run_branch(I_BNOV,   2, 1'b1, 1'b0);
        run_branch(I_BRANCH, 0, 1'b0, 1'b1);
        run_branch(I_NOP,    0, 1'b1, 1'b0);

        // MOVE
        do_reset(I_MOVE);
        step(); step();
        check("mov op", a_op, 2'b00);
        check("mov csel", a_csel, 1);
        check("mov wre", a_wre, 1);
        check("mov fre", a_fre, 0);

        // HALT: terminal until reset
        do_reset(I_HALT);
        step();
        check("hlt dec pc", a_pc, 1);
        check("hlt dec halt", a_halt, 0);
        step();
        for (int i = 0; i < 20; i++) begin
            if (i == 10) instr = I_ADD;
            check($sformatf("hlt%0d halt", i), a_halt, 1);
            check($sformatf("hlt%0d strobes", i), {a_pc, a_br, a_ir, a_wre, a_fre, a_rwe}, 0);
            step();
        end
        rst_n = 1'b0;
        #1;
        check("hlt reset halt", a_halt, 0);
        check("hlt reset ir", a_ir, 1);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
